// File: rtl/seq_check_0257.sv
// Sequence lock checker for a 0-2-5-7 upstream counter: hunts for 0, acquires LOCK_LEN
// in-order samples, then flags violations. Optional sticky error flag under SEQ_CHECK_STICKY_EN.
//
//   state | meaning
//   HUNT  | waiting for a 0 to start acquisition (code 2'b11 also behaves as HUNT)
//   ACQ   | counting consecutive in-order samples towards LOCK_LEN
//   LOCK  | locked; a mismatch pulses err and drops lock
module seq_check_0257 #(
  parameter int LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [2:0] count_in,
`ifdef SEQ_CHECK_STICKY_EN
  input  logic       err_clr,
  output logic       err_sticky,
`endif
  output logic       locked,
  output logic       err,
  output logic [2:0] expected,
  output logic [7:0] err_cnt,
  output logic [7:0] lap_cnt
);

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [2:0] exp_q, exp_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] lap_cnt_q, lap_cnt_d;
  logic [4:0] run_inc;

  function automatic logic [2:0] next_code(input logic [2:0] v);
    case (v)
      3'd0:    next_code = 3'd2;
      3'd2:    next_code = 3'd5;
      3'd5:    next_code = 3'd7;
      default: next_code = 3'd0;
    endcase
  endfunction

  assign run_inc = {1'b0, run_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    lap_cnt_d = lap_cnt_q;
    if (valid_in) begin
      case (state_q)
        ACQ: begin
          if (count_in == exp_q) begin
            exp_d = next_code(exp_q);
            run_d = run_inc[3:0];
            if (run_inc >= 5'(LOCK_LEN)) state_d = LOCK;
          end else if (count_in == 3'd0) begin
            run_d = 4'd1;
            exp_d = 3'd2;
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
            exp_d   = 3'd0;
          end
        end
        LOCK: begin
          if (count_in == exp_q) begin
            exp_d = next_code(exp_q);
            if (count_in == 3'd7) lap_cnt_d = lap_cnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (count_in == 3'd0) begin
              state_d = ACQ;
              run_d   = 4'd1;
              exp_d   = 3'd2;
            end else begin
              state_d = HUNT;
              run_d   = 4'd0;
              exp_d   = 3'd0;
            end
          end
        end
        default: begin
          if (count_in == 3'd0) begin
            // a single accepted 0 already satisfies LOCK_LEN == 1
            state_d = (LOCK_LEN <= 1) ? LOCK : ACQ;
            run_d   = 4'd1;
            exp_d   = 3'd2;
          end else begin
            state_d = HUNT;
            run_d   = 4'd0;
            exp_d   = 3'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      run_q     <= 4'd0;
      exp_q     <= 3'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      lap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      lap_cnt_q <= lap_cnt_d;
    end
  end

`ifdef SEQ_CHECK_STICKY_EN
  logic sticky_q;

  // a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sticky_q <= 1'b0;
    else if (err_d)   sticky_q <= 1'b1;
    else if (err_clr) sticky_q <= 1'b0;
  end

  assign err_sticky = sticky_q;
`endif

  assign locked   = (state_q == LOCK);
  assign err      = err_q;
  assign expected = exp_q;
  assign err_cnt  = err_cnt_q;
  assign lap_cnt  = lap_cnt_q;

endmodule
